// File: rtl/avalon_pio_master.sv
// avalon_pio_master: turns a valid/ready command stream into single Avalon-MM transfers, one response per command.
module avalon_pio_master #(
  parameter int ADDR_W       = 2,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 0,
  parameter int TIMEOUT      = 255,
  parameter int TMO_W        = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest
);
  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT, RESP} state_t;
  state_t            state_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [1:0]        lat_q;
  logic              cmd_ready_q, rsp_valid_q, rsp_err_q, cs_q, write_n_q;
  logic [DATA_W-1:0] rdata_q, wdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic              tmo_hit;
  // Abort on the stall cycle that would bring the count up to TIMEOUT.
  assign tmo_hit = (TIMEOUT != 0) && (tmo_q == TMO_W'(TIMEOUT - 1));
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      tmo_q       <= '0;
      lat_q       <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= '0;
      cs_q        <= 1'b0;
      write_n_q   <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (cmd_valid) begin
          cmd_ready_q <= 1'b0;
          cs_q        <= 1'b1;
          write_n_q   <= ~cmd_write;
          addr_q      <= cmd_addr;
          wdata_q     <= cmd_wdata;
          state_q     <= ACCESS;
        end
        ACCESS: if (!avm_waitrequest) begin
          cs_q      <= 1'b0;
          write_n_q <= 1'b1;
          tmo_q     <= '0;
          rsp_err_q <= 1'b0;
          if (!write_n_q) begin
            rdata_q     <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (READ_LATENCY == 0) begin
            rdata_q     <= avm_readdata;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            lat_q   <= 2'(READ_LATENCY - 1);
            state_q <= RDWAIT;
          end
        end else if (tmo_hit) begin
          cs_q        <= 1'b0;
          write_n_q   <= 1'b1;
          tmo_q       <= '0;
          rsp_err_q   <= 1'b1;
          rdata_q     <= '0;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
        RDWAIT: if (lat_q == '0) begin
          rdata_q     <= avm_readdata;
          rsp_err_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end else begin
          lat_q <= lat_q - 1'b1;
        end
        RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end
  assign cmd_ready      = cmd_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rdata_q;
  assign rsp_err        = rsp_err_q;
  assign avm_address    = addr_q;
  assign avm_chipselect = cs_q;
  assign avm_write_n    = write_n_q;
  assign avm_writedata  = wdata_q;
endmodule

// File: tb/tb_avalon_pio_master.sv
// tb_avalon_pio_master: two instances (latency 0 / timeout 255 and latency 2 / timeout 4) against register-file slave models.
module tb_avalon_pio_master;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0]       cmd_valid, cmd_ready, cmd_write, rsp_valid, rsp_ready, rsp_err, cs, wn, wr;
  logic [1:0][1:0]  cmd_addr, addr;
  logic [1:0][31:0] cmd_wdata, rsp_rdata, wdata, rdata;
  logic [7:0]       stall_req [2];
  logic [7:0]       stall_left [2];
  logic [31:0]      mem [2][4];
  logic [31:0]      ref_mem [2][4];
  logic             pv1, pv2;
  logic [31:0]      pd1, pd2;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    avalon_pio_master #(.ADDR_W(2), .DATA_W(32), .READ_LATENCY(2 * g), .TIMEOUT(g ? 4 : 255), .TMO_W(8)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]), .cmd_write(cmd_write[g]),
      .cmd_addr(cmd_addr[g]), .cmd_wdata(cmd_wdata[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g]),
      .avm_address(addr[g]), .avm_chipselect(cs[g]), .avm_write_n(wn[g]), .avm_writedata(wdata[g]),
      .avm_readdata(rdata[g]), .avm_waitrequest(wr[g])
    );
  end

  // Slave side: register files, programmable stall, and a 2-cycle read pipe for instance 1.
  always_comb begin
    wr[0] = stall_left[0] != 0;
    wr[1] = stall_left[1] != 0;
    rdata[0] = (cs[0] && wn[0]) ? mem[0][addr[0]] : 32'h0;
    rdata[1] = pv2 ? pd2 : 32'h0;
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int d = 0; d < 2; d++) begin
        stall_left[d] <= 8'd0;
        for (int k = 0; k < 4; k++) mem[d][k] <= 32'h0;
      end
      pv1 <= 1'b0;
      pv2 <= 1'b0;
      pd1 <= 32'h0;
      pd2 <= 32'h0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (cmd_valid[d] && cmd_ready[d]) stall_left[d] <= stall_req[d];
        else if (cs[d] && wr[d]) stall_left[d] <= stall_left[d] - 8'd1;
        if (cs[d] && !wn[d] && !wr[d]) mem[d][addr[d]] <= wdata[d];
      end
      pv1 <= cs[1] && wn[1] && !wr[1];
      pd1 <= mem[1][addr[1]];
      pv2 <= pv1;
      pd2 <= pd1;
    end
  end

  function automatic int lat(int d); return d == 1 ? 2 : 0; endfunction
  function automatic int tmo(int d); return d == 1 ? 4 : 255; endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(int d, string tag);
    chk($sformatf("%s_cmd_ready[%0d]", tag, d), 32'(cmd_ready[d]), 32'd1);
    chk($sformatf("%s_rsp_valid[%0d]", tag, d), 32'(rsp_valid[d]), 32'd0);
    chk($sformatf("%s_cs[%0d]", tag, d), 32'(cs[d]), 32'd0);
    chk($sformatf("%s_write_n[%0d]", tag, d), 32'(wn[d]), 32'd1);
  endtask

  // One command: expected outcome and cycle-by-cycle timing derived from stall count, latency and timeout.
  task automatic do_cmd(int d, bit w, logic [1:0] a, logic [31:0] wd, int stall, int hold, bit keep);
    bit          tmo_e;
    logic [31:0] exp_d;
    int          exp_cs, exp_rsp;
    tmo_e   = tmo(d) != 0 && stall >= tmo(d);
    exp_d   = (w || tmo_e) ? 32'h0 : ref_mem[d][a];
    exp_cs  = tmo_e ? tmo(d) : stall + 1;
    exp_rsp = tmo_e ? tmo(d) + 1 : stall + 2 + (w ? 0 : lat(d));
    if (w && !tmo_e) ref_mem[d][a] = wd;
    @(negedge clk);
    chk($sformatf("cmd_ready_before[%0d]", d), 32'(cmd_ready[d]), 32'd1);
    cmd_valid[d] = 1'b1;
    cmd_write[d] = w;
    cmd_addr[d]  = a;
    cmd_wdata[d] = wd;
    stall_req[d] = 8'(stall);
    for (int i = 1; i <= exp_rsp; i++) begin
      @(negedge clk);
      if (!keep) cmd_valid[d] = 1'b0;
      chk($sformatf("cs[%0d]@%0d", d, i), 32'(cs[d]), 32'(i <= exp_cs));
      chk($sformatf("write_n[%0d]@%0d", d, i), 32'(wn[d]), 32'(i <= exp_cs ? !w : 1'b1));
      chk($sformatf("rsp_valid[%0d]@%0d", d, i), 32'(rsp_valid[d]), 32'(i == exp_rsp));
      chk($sformatf("cmd_ready_busy[%0d]@%0d", d, i), 32'(cmd_ready[d]), 32'd0);
      if (i <= exp_cs) begin
        chk($sformatf("address[%0d]@%0d", d, i), 32'(addr[d]), 32'(a));
        if (w) chk($sformatf("writedata[%0d]@%0d", d, i), wdata[d], wd);
      end
    end
    chk($sformatf("rsp_err[%0d]", d), 32'(rsp_err[d]), 32'(tmo_e));
    chk($sformatf("rsp_rdata[%0d]", d), rsp_rdata[d], exp_d);
    for (int h = 1; h <= hold; h++) begin
      @(negedge clk);
      chk($sformatf("hold_rsp_valid[%0d]@%0d", d, h), 32'(rsp_valid[d]), 32'd1);
      chk($sformatf("hold_rdata[%0d]@%0d", d, h), rsp_rdata[d], exp_d);
      chk($sformatf("hold_err[%0d]@%0d", d, h), 32'(rsp_err[d]), 32'(tmo_e));
      chk($sformatf("hold_cmd_ready[%0d]@%0d", d, h), 32'(cmd_ready[d]), 32'd0);
      chk($sformatf("hold_cs[%0d]@%0d", d, h), 32'(cs[d]), 32'd0);
    end
    rsp_ready[d] = 1'b1;
    cmd_valid[d] = 1'b0;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    chk_idle_outputs(d, "after_rsp");
  endtask

  initial begin
    cmd_valid = '0;
    cmd_write = '0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = '0;
    for (int d = 0; d < 2; d++) begin
      stall_req[d] = 8'd0;
      for (int k = 0; k < 4; k++) ref_mem[d][k] = 32'h0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk_idle_outputs(d, "reset");
      chk($sformatf("reset_rsp_err[%0d]", d), 32'(rsp_err[d]), 32'd0);
      chk($sformatf("reset_rsp_rdata[%0d]", d), rsp_rdata[d], 32'h0);
      chk($sformatf("reset_address[%0d]", d), 32'(addr[d]), 32'd0);
      chk($sformatf("reset_writedata[%0d]", d), wdata[d], 32'h0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    chk_idle_outputs(0, "post_reset");

    do_cmd(0, 1'b1, 2'd0, 32'h0000_07FF, 0, 0, 1'b0);
    do_cmd(0, 1'b0, 2'd0, 32'h0, 0, 0, 1'b0);
    do_cmd(0, 1'b1, 2'd0, 32'h0000_0123, 0, 0, 1'b0);
    do_cmd(0, 1'b0, 2'd0, 32'h0, 0, 0, 1'b0);
    do_cmd(0, 1'b1, 2'd2, 32'hCAFE_F00D, 5, 0, 1'b0);
    do_cmd(0, 1'b0, 2'd2, 32'h0, 5, 0, 1'b0);
    do_cmd(0, 1'b0, 2'd2, 32'h0, 1, 10, 1'b1);

    do_cmd(1, 1'b1, 2'd2, 32'hDEAD_BEEF, 0, 0, 1'b0);
    do_cmd(1, 1'b0, 2'd2, 32'h0, 0, 0, 1'b0);
    do_cmd(1, 1'b0, 2'd2, 32'h0, 3, 0, 1'b0);
    do_cmd(1, 1'b0, 2'd2, 32'h0, 4, 0, 1'b0);
    do_cmd(1, 1'b1, 2'd2, 32'h1111_2222, 20, 0, 1'b0);
    do_cmd(1, 1'b0, 2'd2, 32'h0, 0, 0, 1'b0);

    for (int n = 0; n < 24; n++)
      do_cmd(n % 2, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
             (n % 2) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 3)),
             int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));

    // Reset while instance 0 is stalled in its address phase: no response may follow.
    @(negedge clk);
    cmd_valid[0] = 1'b1;
    cmd_write[0] = 1'b0;
    cmd_addr[0]  = 2'd1;
    stall_req[0] = 8'd10;
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    @(negedge clk);
    chk("mid_access_cs", 32'(cs[0]), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk_idle_outputs(0, "async_reset");
    chk("async_reset_address", 32'(addr[0]), 32'd0);
    chk("async_reset_writedata", wdata[0], 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 4; k++) ref_mem[d][k] = 32'h0;
    rsp_ready[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("no_rsp_after_reset@%0d", i), 32'(rsp_valid[0]), 32'd0);
      chk($sformatf("no_cs_after_reset@%0d", i), 32'(cs[0]), 32'd0);
    end
    rsp_ready[0] = 1'b0;
    do_cmd(0, 1'b0, 2'd1, 32'h0, 0, 0, 1'b0);
    do_cmd(0, 1'b1, 2'd3, 32'h5A5A_A5A5, 2, 1, 1'b0);
    do_cmd(0, 1'b0, 2'd3, 32'h0, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
